aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
Round sequencer for the AES core. It drives the generic round counter (cnt_en, cnt_clr), consumes the counter's value as round_q, and produces the per-round datapath controls: initial-AddRoundKey select, final-round select (skip MixColumns), datapath enable and the key-schedule round constant. It sits between the host load/start interface and the round datapath/key expander.

Parameters:
NR, 10, number of AES rounds (10/12/14); legal range 2..2**CW-1
CW, 4, width of round_q (must match counter N)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  begin encryption; sampled only in IDLE
round_q  in  CW  current round number from the round counter
cnt_en  out  1  round counter enable (counter inc tied to 1)
cnt_clr  out  1  round counter reset; glitch-free, decoded from a single state flop
round_en  out  1  datapath state/key register load enable
sel_init  out  1  select initial AddRoundKey path
sel_final  out  1  select final round (no MixColumns)
rcon  out  8  round constant for round_q
ready  out  1  idle, will accept start
done  out  1  one-cycle completion pulse

Behaviour:
- Reset and clock are as decided: one clock, reset asynchronous and active-high.
- State register is one-hot: IDLE, INIT, ROUND, FINAL, DONE. All outputs are decoded from single state flops, with no combinational terms from start. The exception is rcon, which is combinational from round_q.
- Reset (async) forces IDLE. During and after reset: ready=1, cnt_clr=1; cnt_en, round_en, sel_init, sel_final, done all 0.
- IDLE:
  - ready=1, cnt_clr=1 (holds the counter at 0).
  - start=1 at a rising edge -> INIT.
- INIT (exactly 1 cycle):
  - sel_init=1, round_en=1, cnt_en=1.
  - Next state: ROUND; the counter advances to 1.
- ROUND:
  - round_en=1, cnt_en=1.
  - If round_q >= NR-1 -> FINAL, else stay.
  - The >= check also guards against a counter overshoot.
- FINAL (1 cycle):
  - sel_final=1, round_en=1, cnt_en=0; round_q==NR here.
  - Next state: DONE.
- DONE (1 cycle):
  - done=1, ready=0.
  - Next state: IDLE. A start during DONE is ignored.
- Latency: sampling edge E enters INIT.
  - ROUND covers edges E+1..E+NR-1.
  - FINAL is entered at E+NR.
  - done rises at E+NR+1 and falls at E+NR+2.
  - round_en is high for exactly NR+1 consecutive cycles per operation.
- start is ignored in every state except IDLE; busy = !ready.
- rcon is a function of round_q, valid whenever round_en=1:
  - round_q 1..10 -> 01,02,04,08,10,20,40,80,1B,36.
  - round_q 0 or >10 -> 00.
- Reset mid-operation aborts immediately (async):
  - no done pulse;
  - cnt_clr reasserts;
  - the next start restarts from INIT.
- Back-to-back: start held high gives a new INIT on the edge after the DONE->IDLE transition, so there is a 1-cycle IDLE gap minimum.

Test Plan:
- Reset, NR=10, 1-cycle start pulse at edge E:
  - sel_init high in cycle after E;
  - round_q steps 1..9 with round_en=1;
  - sel_final with round_q=10;
  - done high exactly one cycle after edge E+11;
  - ready low from E through DONE.
- rcon check over one operation:
  - rcon=00 in INIT;
  - rcon sequence 01,02,04,08,10,20,40,80,1B during ROUND;
  - rcon=36 in FINAL.
- start held high continuously for 40 cycles:
  - operations complete with done pulses 13 cycles apart (12-cycle operation + 1 IDLE);
  - start during DONE/ROUND never re-enters INIT early.
- Async reset asserted mid-ROUND at round_q=5:
  - outputs go to reset values without waiting for clk;
  - counter reads 0;
  - no done;
  - a subsequent start completes normally.
- NR=14, CW=4 (AES-256):
  - round_en high 15 cycles;
  - sel_final with round_q=14;
  - rcon=00 for round_q 11..14;
  - done at E+15.
- Counter overshoot (bench forces round_q=12 in ROUND, NR=10) -> FINAL on the next edge, then DONE and IDLE with no hang.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: one-hot FSM driving the external round counter and the
// per-round datapath controls (initial/final select, load enable, rcon).
module aes_round_ctrl #(
    parameter int unsigned NR = 10,
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] round_q,
    output logic          cnt_en,
    output logic          cnt_clr,
    output logic          round_en,
    output logic          sel_init,
    output logic          sel_final,
    output logic [7:0]    rcon,
    output logic          ready,
    output logic          done
);

    // Bit positions within the one-hot state vector.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_idx_t;

    localparam logic [CW-1:0] LAST_ROUND = CW'(NR - 1);

    logic [4:0]  state;
    logic [4:0]  state_next;
    logic [31:0] round_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= '0;
            state[S_IDLE] <= 1'b1;
        end else begin
            state <= state_next;
        end
    end

    // DONE and any vector with no recognised bit fall back to IDLE.
    always_comb begin
        state_next = '0;
        if (state[S_IDLE]) begin
            if (start) state_next[S_INIT] = 1'b1;
            else       state_next[S_IDLE] = 1'b1;
        end else if (state[S_INIT]) begin
            state_next[S_ROUND] = 1'b1;
        end else if (state[S_ROUND]) begin
            if (round_q >= LAST_ROUND) state_next[S_FINAL] = 1'b1;
            else                       state_next[S_ROUND] = 1'b1;
        end else if (state[S_FINAL]) begin
            state_next[S_DONE] = 1'b1;
        end else begin
            state_next[S_IDLE] = 1'b1;
        end
    end

    assign ready     = state[S_IDLE];
    assign cnt_clr   = state[S_IDLE];
    assign sel_init  = state[S_INIT];
    assign sel_final = state[S_FINAL];
    assign done      = state[S_DONE];
    assign cnt_en    = state[S_INIT] | state[S_ROUND];
    assign round_en  = state[S_INIT] | state[S_ROUND] | state[S_FINAL];

    assign round_ext = 32'(round_q);

    always_comb begin
        rcon = 8'h00;
        case (round_ext)
            32'd1:   rcon = 8'h01;
            32'd2:   rcon = 8'h02;
            32'd3:   rcon = 8'h04;
            32'd4:   rcon = 8'h08;
            32'd5:   rcon = 8'h10;
            32'd6:   rcon = 8'h20;
            32'd7:   rcon = 8'h40;
            32'd8:   rcon = 8'h80;
            32'd9:   rcon = 8'h1B;
            32'd10:  rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: NR=10 and NR=14 instances, each with a
// bench-side round counter driven by the DUT's cnt_en/cnt_clr.
module tb_aes_round_ctrl;

    localparam logic [6:0] F_IDLE  = 7'b1100000;
    localparam logic [6:0] F_INIT  = 7'b0011100;
    localparam logic [6:0] F_ROUND = 7'b0011000;
    localparam logic [6:0] F_FINAL = 7'b0001010;
    localparam logic [6:0] F_DONE  = 7'b0000001;

    typedef struct {
        logic       start;
        logic [6:0] flags;   // {ready,cnt_clr,cnt_en,round_en,sel_init,sel_final,done}
        logic [3:0] q;
        logic [7:0] rcon;
    } vec_t;

    logic clk = 1'b0;
    logic reset, start10, start14, force_en;
    logic [3:0] force_val, q10, q14, rq10;
    logic en10, clr10, ren10, init10, fin10, ready10, done10;
    logic en14, clr14, ren14, init14, fin14, ready14, done14;
    logic [7:0] rcon10, rcon14;
    logic [6:0] f10, f14;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10), .CW(4)) u10 (
        .clk(clk), .reset(reset), .start(start10), .round_q(rq10),
        .cnt_en(en10), .cnt_clr(clr10), .round_en(ren10), .sel_init(init10),
        .sel_final(fin10), .rcon(rcon10), .ready(ready10), .done(done10)
    );

    aes_round_ctrl #(.NR(14), .CW(4)) u14 (
        .clk(clk), .reset(reset), .start(start14), .round_q(q14),
        .cnt_en(en14), .cnt_clr(clr14), .round_en(ren14), .sel_init(init14),
        .sel_final(fin14), .rcon(rcon14), .ready(ready14), .done(done14)
    );

    // Counters clear only through cnt_clr, so a zero count depends on the DUT.
    always_ff @(posedge clk) begin
        if (clr10)     q10 <= '0;
        else if (en10) q10 <= q10 + 4'd1;
        if (clr14)     q14 <= '0;
        else if (en14) q14 <= q14 + 4'd1;
    end

    assign rq10 = force_en ? force_val : q10;
    assign f10  = {ready10, clr10, en10, ren10, init10, fin10, done10};
    assign f14  = {ready14, clr14, en14, ren14, init14, fin14, done14};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready10(input string name, input int limit);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (ready10) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[14];
        logic [7:0] rc_tab[0:10];
        int dones[$];
        int ren_cnt, done_at, rc_chk, rc_bad, early_init, done_seen;
        logic prev_ready;
        logic [3:0] final_q;

        rc_tab = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                   8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        tbl[0] = '{start: 1'b1, flags: F_INIT, q: 4'd0, rcon: 8'h00};
        for (int k = 1; k <= 9; k++)
            tbl[k] = '{start: 1'(k % 2), flags: F_ROUND, q: 4'(k), rcon: rc_tab[k]};
        tbl[10] = '{start: 1'b1, flags: F_FINAL, q: 4'd10, rcon: 8'h36};
        tbl[11] = '{start: 1'b1, flags: F_DONE,  q: 4'd10, rcon: 8'h36};
        tbl[12] = '{start: 1'b1, flags: F_IDLE,  q: 4'd10, rcon: 8'h36};
        tbl[13] = '{start: 1'b0, flags: F_IDLE,  q: 4'd0,  rcon: 8'h00};

        // Reset state, visible before any clock edge.
        reset = 1'b1; start10 = 1'b0; start14 = 1'b0;
        force_en = 1'b0; force_val = 4'd0;
        #1;
        check("rst_flags10", 32'(f10), 32'(F_IDLE));
        check("rst_flags14", 32'(f14), 32'(F_IDLE));
        repeat (2) @(posedge clk);
        #1;
        check("rst_cnt10", 32'(rq10), 32'd0);
        @(negedge clk) reset = 1'b0;

        // One NR=10 operation, cycle by cycle.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk) start10 = tbl[i].start;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), 32'({f10, rq10, rcon10}),
                  32'({tbl[i].flags, tbl[i].q, tbl[i].rcon}));
        end

        // start held high for 40 cycles: INIT at 0, 13, 26, 39; done at 11, 24, 37.
        @(negedge clk) start10 = 1'b1;
        prev_ready = 1'b1;
        early_init = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done10) dones.push_back(c);
            if (init10 && !prev_ready) early_init++;
            prev_ready = ready10;
        end
        start10 = 1'b0;
        check("b2b_done_count", 32'(dones.size()), 32'd3);
        check("b2b_first_done", 32'(dones.size() > 0 ? dones[0] : -1), 32'd11);
        for (int i = 1; i < dones.size(); i++)
            check($sformatf("b2b_gap%0d", i), 32'(dones[i] - dones[i-1]), 32'd13);
        check("b2b_early_init", 32'(early_init), 32'd0);
        wait_ready10("b2b_drain", 30);
        @(posedge clk); #1;

        // Async reset in the middle of ROUND at round_q=5.
        @(negedge clk) start10 = 1'b1;
        @(posedge clk); #1;
        start10 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rq10 == 4'd5) break;
            @(posedge clk); #1;
        end
        check("mid_reach_q5", 32'({rq10, f10}), 32'({4'd5, F_ROUND}));
        #1 reset = 1'b1;
        #1;
        check("mid_async_flags", 32'(f10), 32'(F_IDLE));
        done_seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done10) done_seen++;
        end
        check("mid_cnt_zero", 32'(rq10), 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        if (done10) done_seen++;
        check("mid_no_done", 32'(done_seen), 32'd0);
        @(negedge clk) start10 = 1'b1;
        @(posedge clk); #1;
        start10 = 1'b0;
        check("restart_init", 32'({f10, rq10}), 32'({F_INIT, 4'd0}));
        done_at = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done10) begin
                done_at = c;
                break;
            end
        end
        check("restart_done_at", 32'(done_at), 32'd11);
        wait_ready10("restart_idle", 5);

        // NR=14 operation.
        @(negedge clk) start14 = 1'b1;
        ren_cnt = 0; done_at = -1; rc_chk = 0; rc_bad = 0; final_q = 4'hF;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            start14 = 1'b0;
            if (ren14) ren_cnt++;
            if (fin14) final_q = q14;
            if (ren14 && q14 >= 4'd11) begin
                rc_chk++;
                if (rcon14 !== 8'h00) rc_bad++;
            end
            if (done14 && done_at < 0) done_at = c;
        end
        check("nr14_round_en", 32'(ren_cnt), 32'd15);
        check("nr14_final_q", 32'(final_q), 32'd14);
        check("nr14_rcon_checked", 32'(rc_chk), 32'd4);
        check("nr14_rcon_zero", 32'(rc_bad), 32'd0);
        check("nr14_done_at", 32'(done_at), 32'd15);
        check("nr14_idle", 32'(f14), 32'(F_IDLE));

        // Counter overshoot: round_q jumps to 12 in ROUND with NR=10.
        @(negedge clk) start10 = 1'b1;
        @(posedge clk); #1;
        start10 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rq10 == 4'd3) break;
            @(posedge clk); #1;
        end
        check("ovs_in_round", 32'({rq10, f10}), 32'({4'd3, F_ROUND}));
        force_val = 4'd12;
        force_en  = 1'b1;
        @(posedge clk); #1;
        check("ovs_final", 32'(f10), 32'(F_FINAL));
        @(posedge clk); #1;
        check("ovs_done", 32'(f10), 32'(F_DONE));
        @(posedge clk); #1;
        check("ovs_idle", 32'(f10), 32'(F_IDLE));
        force_en = 1'b0;
        @(posedge clk); #1;
        check("ovs_cnt_clr", 32'({f10, rq10}), 32'({F_IDLE, 4'd0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
